mem_data_bridge: RTL
====================

// Module: mem_data_bridge
// PURPOSE
//  - M-stage data-memory initiator: turns the M-stage load/store request into a transaction on the
//    SRAM-like split data bus (addr phase / data phase). Returns aligned, extended readdataM to the
//    MEM/WB register and drives stallM to hold the pipeline while the bus is busy.
//  - Detects misaligned accesses (adelM/adesM). A misaligned access never reaches the bus.
// PARAMETERS
//  ADDR_W  32  bus address width; only 32 is supported.
//  DATA_W  32  bus data width; only 32 is supported, 4 byte lanes.
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  memreqM      in   1   M stage holds a load/store; held stable while stallM=1
//  memwriteM    in   1   1=store, 0=load
//  memsizeM     in   2   00 byte, 01 half, 10 word (11 treated as word)
//  memsignedM   in   1   load sign-extends when 1, zero-extends when 0
//  addrM        in   32  byte address
//  writedataM   in   32  store data, right-aligned
//  flushM       in   1   exception flush of the M-stage instruction
//  readdataM    out  32  load result, valid in the cycle stallM falls
//  stallM       out  1   hold IF..M and bubble MEM/WB
//  adelM/adesM  out  1   misaligned load / store (combinational)
//  data_req     out  1   address-phase request
//  data_wr      out  1   write request
//  data_size    out  2   = memsizeM, latched
//  data_addr    out  32  addrM, latched
//  data_wstrb   out  4   byte enables for stores; 0 for loads
//  data_wdata   out  32  store data replicated into byte lanes
//  data_addr_ok in   1   address phase accepted this cycle
//  data_data_ok in   1   data phase complete this cycle; rdata valid
//  data_rdata   in   32  raw read word
// BEHAVIOUR
//  - Reset: state=IDLE. data_req=0, data_wr=0, data_wstrb=0, data_addr=0, data_wdata=0,
//    readdataM=0. stallM=0 while memreqM=0.
//  - Alignment: misaligned when half and addr[0]=1, or word and addr[1:0]!=0.
//    adelM=memreqM&~memwriteM&mis. adesM=memreqM&memwriteM&mis.
//    A misaligned access never stalls.
//  - Store lanes: byte -> wdata={4{wd[7:0]}} with wstrb=0001<<addr[1:0];
//    half -> {2{wd[15:0]}} with wstrb=0011<<addr[1:0]; word -> wstrb=1111.
//  - FSM states: IDLE, ADDR, DATA, DONE, DRAIN.
//    IDLE : memreqM&~mis&~flushM -> ADDR; latch the bus fields. stallM=1 in this cycle.
//    ADDR : data_req=1 and fields stable. addr_ok&data_ok -> DONE and capture rdata;
//           addr_ok only -> DATA; flushM&~addr_ok -> IDLE and drop req next cycle.
//    DATA : data_ok -> DONE and capture rdata; flushM -> DRAIN.
//    DONE : stallM=0 and readdataM is valid; -> IDLE. Minimum latency is 3 cycles, IDLE to DONE.
//    DRAIN: wait for data_ok, discard the data -> IDLE. stallM=0 because the flush owns the pipe.
//           The outstanding transaction is never abandoned.
//  - stallM=memreqM&~mis&~flushM&(state in IDLE/ADDR/DATA). In DONE and DRAIN, stallM=0.
//  - Load extract: lane=addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend.
//    The captured word is registered; readdataM is computed from it combinationally.
//  - Stores: DONE is reached on data_ok as well; readdataM is don't-care.
//  - Async reset in any state: the FSM returns to IDLE at once and data_req drops.
//    A bus transaction in flight at reset is the bus's responsibility.
// STRUCTURE
//  - Shared package mem_defs: SZ_BYTE/SZ_HALF/SZ_WORD, the 3-bit FSM state encoding,
//    and the wstrb lane function.
//  - Sub-module mem_load_ext: combinational lane select plus extension
//    (word, addr[1:0], size, signed -> 32). It is reused by any future uncached path.
//  - Top: the FSM, the latched bus-field registers, the rdata capture register and the store lane packing.
// TESTING
//  1. LW addr=0x100: addr_ok in ADDR, data_ok 2 cycles later with rdata=0xDEADBEEF
//     -> stallM high 4 cycles, readdataM=0xDEADBEEF in DONE.
//  2. LB signed addr=0x103, rdata=0x80FF0011 -> 0xFFFFFF80.
//     LHU addr=0x102, same rdata -> 0x000080FF.
//  3. SB addr=0x201, wd=0x000000AB -> data_wdata=0xABABABAB, wstrb=0010, data_wr=1, size=00.
//  4. LW addr=0x102 -> adelM=1, stallM=0, data_req never asserts.
//     SH addr=0x301 -> adesM=1, no request.
//  5. flushM in DATA before data_ok -> DRAIN, stallM=0. A late data_ok is discarded,
//     readdataM is unchanged and the FSM returns to IDLE.
//  6. addr_ok and data_ok both in the first ADDR cycle -> DONE next cycle (3-cycle latency).
//     reset asserted in DATA -> state IDLE and data_req=0 immediately.

Source files
------------

// File: rtl/mem_data_bridge_pkg.sv
// ============================================================================
// Package : mem_defs
// Shared size codes, FSM encoding and store lane helpers for the data bridge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_defs;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } memState_t;

    // Size code 2'b11 falls into the word arm everywhere.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addrLo[0];
            default: return |addrLo;
        endcase
    endfunction

    function automatic logic [3:0] laneStrobe(input logic [1:0] size, input logic [1:0] addrLo);
        case (size)
            SZ_BYTE: return 4'b0001 << addrLo;
            SZ_HALF: return 4'b0011 << addrLo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] laneReplicate(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_data_bridge_load_ext.sv
// ============================================================================
// Module  : mem_load_ext
// Selects the addressed byte/half lane of a read word and sign/zero extends.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_ext
    import mem_defs::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic        isSigned,
    output logic [31:0] result
);

    logic [31:0] w_byteShift;
    logic [31:0] w_halfShift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byteShift = word >> {addrLo, 3'b000};
        w_halfShift = word >> {addrLo[1], 4'b0000};
        w_byte      = w_byteShift[7:0];
        w_half      = w_halfShift[15:0];
        case (size)
            SZ_BYTE: result = {{24{isSigned & w_byte[7]}}, w_byte};
            SZ_HALF: result = {{16{isSigned & w_half[15]}}, w_half};
            default: result = word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_data_bridge.sv
// ============================================================================
// Module  : mem_data_bridge
// M-stage load/store initiator onto the split addr/data SRAM-like bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_data_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memreqM,
    input  logic                  memwriteM,
    input  logic [1:0]            memsizeM,
    input  logic                  memsignedM,
    input  logic [ADDR_W-1:0]     addrM,
    input  logic [DATA_W-1:0]     writedataM,
    input  logic                  flushM,
    output logic [DATA_W-1:0]     readdataM,
    output logic                  stallM,
    output logic                  adelM,
    output logic                  adesM,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_W-1:0]     data_addr,
    output logic [DATA_W/8-1:0]   data_wstrb,
    output logic [DATA_W-1:0]     data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_W-1:0]     data_rdata
);

    import mem_defs::*;

    memState_t   r_state;
    memState_t   w_nextState;
    logic        w_mis;
    logic        w_start;
    logic        w_capture;
    logic        r_signed;
    logic [31:0] r_capWord;

    assign w_mis   = isMisaligned(memsizeM, addrM[1:0]);
    assign adelM   = memreqM & ~memwriteM & w_mis;
    assign adesM   = memreqM &  memwriteM & w_mis;
    assign w_start = (r_state == ST_IDLE) & memreqM & ~w_mis & ~flushM;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // data_req is decoded from state so an async reset drops it immediately.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        data_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_nextState = ST_ADDR;
            end
            ST_ADDR: begin
                data_req = 1'b1;
                if (data_addr_ok && data_data_ok) begin
                    w_nextState = ST_DONE;
                    w_capture   = 1'b1;
                end else if (data_addr_ok) begin
                    w_nextState = ST_DATA;
                end else if (flushM) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (data_data_ok) begin
                    w_nextState = ST_DONE;
                    w_capture   = 1'b1;
                end else if (flushM) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            ST_DRAIN: begin
                if (data_data_ok) w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        stallM = memreqM & ~w_mis & ~flushM &
                 ((r_state == ST_IDLE) | (r_state == ST_ADDR) | (r_state == ST_DATA));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_wr    <= 1'b0;
            data_size  <= SZ_BYTE;
            data_addr  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
            r_signed   <= 1'b0;
        end else if (w_start) begin
            data_wr    <= memwriteM;
            data_size  <= memsizeM;
            data_addr  <= addrM;
            data_wstrb <= memwriteM ? laneStrobe(memsizeM, addrM[1:0]) : 4'b0000;
            data_wdata <= laneReplicate(memsizeM, writedataM);
            r_signed   <= memsignedM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_capWord <= '0;
        end else if (w_capture) begin
            r_capWord <= data_rdata;
        end
    end

    mem_load_ext u_loadExt (
        .word     (r_capWord),
        .addrLo   (data_addr[1:0]),
        .size     (data_size),
        .isSigned (r_signed),
        .result   (readdataM)
    );

endmodule

`default_nettype wire
